// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA pipeline.
package vga_pkg;

    typedef logic [10:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator (master) and the drawers (slave).
interface vga_timing_gen_if ();
    import vga_pkg::*;

    logic   pixelEn;
    coord_t pixelX;
    coord_t pixelY;
    logic   hSync;
    logic   vSync;
    logic   blankN;
    logic   startOfFrame;

    modport master (
        input  pixelEn,
        output pixelX, pixelY, hSync, vSync, blankN, startOfFrame
    );

    modport slave (
        output pixelEn,
        input  pixelX, pixelY, hSync, vSync, blankN, startOfFrame
    );

endinterface

// File: rtl/vga_sync_delay.sv
// Enabled shift register for {hs, vs, vis}; DEPTH=0 is a combinational pass-through.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  sync_t d,
    output sync_t q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            sync_t stage [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage[i] <= SYNC_IDLE;
                    end
                end else if (en) begin
                    stage[0] <= d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, raw sync/visible decode and aligned sync outputs for the drawers.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT    = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK     = vga_pkg::H_BACK,
    parameter int unsigned V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT    = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK     = vga_pkg::V_BACK,
    parameter int unsigned SYNC_DELAY = 1
) (
    input logic              clk,
    input logic              reset,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam vga_pkg::coord_t H_LAST = vga_pkg::coord_t'(H_TOT - 1);
    localparam vga_pkg::coord_t V_LAST = vga_pkg::coord_t'(V_TOT - 1);
    localparam vga_pkg::coord_t X_VIS  = vga_pkg::coord_t'(H_VISIBLE);
    localparam vga_pkg::coord_t Y_VIS  = vga_pkg::coord_t'(V_VISIBLE);
    localparam vga_pkg::coord_t HS_LO  = vga_pkg::coord_t'(H_VISIBLE + H_FRONT);
    localparam vga_pkg::coord_t HS_HI  = vga_pkg::coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam vga_pkg::coord_t VS_LO  = vga_pkg::coord_t'(V_VISIBLE + V_FRONT);
    localparam vga_pkg::coord_t VS_HI  = vga_pkg::coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    generate
        if (H_TOT > 2047 || V_TOT > 2047) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit 11-bit coordinates");
        end
        if (SYNC_DELAY > 7) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be 0..7");
        end
    endgenerate

    vga_pkg::coord_t px;
    vga_pkg::coord_t py;
    logic            sof;
    logic            x_last;
    logic            y_last;
    vga_pkg::sync_t  raw;
    vga_pkg::sync_t  dly;

    always_comb begin
        x_last = (px == H_LAST);
        y_last = (py == V_LAST);
    end

    // sof is decoded from the pre-update counters so it lines up with (0, V_VISIBLE).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px  <= '0;
            py  <= '0;
            sof <= 1'b0;
        end else begin
            sof <= 1'b0;
            if (vga.pixelEn) begin
                sof <= x_last && (py == Y_VIS - 11'd1);
                if (x_last) begin
                    px <= '0;
                    py <= y_last ? '0 : py + 11'd1;
                end else begin
                    px <= px + 11'd1;
                end
            end
        end
    end

    always_comb begin
        raw     = vga_pkg::SYNC_IDLE;
        raw.hs  = !((px >= HS_LO) && (px < HS_HI));
        raw.vs  = !((py >= VS_LO) && (py < VS_HI));
        raw.vis = (px < X_VIS) && (py < Y_VIS);
    end

    vga_sync_delay #(
        .DEPTH(SYNC_DELAY)
    ) u_sync_delay (
        .clk (clk),
        .rst (reset),
        .en  (vga.pixelEn),
        .d   (raw),
        .q   (dly)
    );

    assign vga.pixelX       = px;
    assign vga.pixelY       = py;
    assign vga.hSync        = dly.hs;
    assign vga.vSync        = dly.vs;
    assign vga.blankN       = dly.vis;
    assign vga.startOfFrame = sof;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: three builds (SYNC_DELAY 0/1/3) on a reduced raster share one stimulus.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HV = 20, HF = 4, HSW = 6, HB = 4;
    localparam int VV = 8,  VF = 2, VSW = 2, VB = 3;
    localparam int HT = HV + HF + HSW + HB;
    localparam int VT = VV + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    typedef struct {
        int         x;
        int         y;
        logic [2:0] s0;
        logic [2:0] s1;
        logic [2:0] s3;
        logic       sof;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pen = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mx, my;
    logic [2:0] hist[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    vga_timing_gen_if if0 ();
    vga_timing_gen_if if1 ();
    vga_timing_gen_if if3 ();
    assign if0.pixelEn = pen;
    assign if1.pixelEn = pen;
    assign if3.pixelEn = pen;

    vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
                     .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
                     .SYNC_DELAY(0)) dut0 (.clk(clk), .reset(reset), .vga(if0.master));
    vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
                     .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
                     .SYNC_DELAY(1)) dut1 (.clk(clk), .reset(reset), .vga(if1.master));
    vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
                     .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
                     .SYNC_DELAY(3)) dut3 (.clk(clk), .reset(reset), .vga(if3.master));

    function automatic logic [2:0] raw_of(input int x, input int y);
        logic hs, vs, vis;
        hs  = (x < HV + HF) || (x >= HV + HF + HSW);
        vs  = (y < VV + VF) || (y >= VV + VF + VSW);
        vis = (x < HV) && (y < VV);
        return {hs, vs, vis};
    endfunction

    task automatic model_reset();
        mx = 0;
        my = 0;
        hist.delete();
        repeat (8) hist.push_front(3'b110);
    endtask

    // One clk: drive pixelEn, push the model's prediction, then pop and compare after the edge.
    task automatic step(input logic en);
        exp_t e;
        pen = en;
        if (en) begin
            hist.push_front(raw_of(mx, my));
            void'(hist.pop_back());
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        e.x = mx;
        e.y = my;
        e.s0 = raw_of(mx, my);
        e.s1 = hist[0];
        e.s3 = hist[2];
        e.sof = en && (mx == 0) && (my == VV);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        checks++;
        if ({if1.pixelX, if1.pixelY} !== {coord_t'(e.x), coord_t'(e.y)}) begin
            errors++;
            $display("FAIL coords cyc=%0d got (%0d,%0d) want (%0d,%0d)", cyc, if1.pixelX, if1.pixelY, e.x, e.y);
        end
        checks++;
        if ({if0.pixelX, if0.pixelY, if3.pixelX, if3.pixelY} !== {coord_t'(e.x), coord_t'(e.y), coord_t'(e.x), coord_t'(e.y)}) begin
            errors++;
            $display("FAIL coords_d0d3 cyc=%0d got (%0d,%0d)/(%0d,%0d) want (%0d,%0d)", cyc, if0.pixelX, if0.pixelY, if3.pixelX, if3.pixelY, e.x, e.y);
        end
        checks++;
        if ({if0.hSync, if0.vSync, if0.blankN} !== e.s0) begin
            errors++;
            $display("FAIL sync_d0 cyc=%0d got %b want %b", cyc, {if0.hSync, if0.vSync, if0.blankN}, e.s0);
        end
        checks++;
        if ({if1.hSync, if1.vSync, if1.blankN} !== e.s1) begin
            errors++;
            $display("FAIL sync_d1 cyc=%0d got %b want %b", cyc, {if1.hSync, if1.vSync, if1.blankN}, e.s1);
        end
        checks++;
        if ({if3.hSync, if3.vSync, if3.blankN} !== e.s3) begin
            errors++;
            $display("FAIL sync_d3 cyc=%0d got %b want %b", cyc, {if3.hSync, if3.vSync, if3.blankN}, e.s3);
        end
        checks++;
        if ({if0.startOfFrame, if1.startOfFrame, if3.startOfFrame} !== {3{e.sof}}) begin
            errors++;
            $display("FAIL sof cyc=%0d got %b want %b", cyc, {if0.startOfFrame, if1.startOfFrame, if3.startOfFrame}, {3{e.sof}});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pen = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            checks++;
            if ({if1.pixelX, if1.pixelY, if1.hSync, if1.vSync, if1.blankN, if1.startOfFrame} !== {22'd0, 4'b1100}) begin
                errors++;
                $display("FAIL reset_d1 got x=%0d y=%0d hvbs=%b want x=0 y=0 hvbs=1100", if1.pixelX, if1.pixelY,
                         {if1.hSync, if1.vSync, if1.blankN, if1.startOfFrame});
            end
            checks++;
            if ({if3.hSync, if3.vSync, if3.blankN, if3.startOfFrame} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_d3 got hvbs=%b want 1100", {if3.hSync, if3.vSync, if3.blankN, if3.startOfFrame});
            end
        end
        model_reset();
        reset = 1'b0;
        step(1'b1);
        checks++;
        if (if1.pixelX !== 11'd1) begin
            errors++;
            $display("FAIL first_step got x=%0d want 1", if1.pixelX);
        end
    endtask

    task automatic test_line();
        int lows = 0;
        int first_x = -1;
        int px_prev, py_prev;
        for (int i = 0; i < HT; i++) begin
            px_prev = int'(if1.pixelX);
            py_prev = int'(if1.pixelY);
            step(1'b1);
            if (!if1.hSync) begin
                lows++;
                if (first_x < 0) first_x = int'(if1.pixelX);
            end
            if (px_prev == HT - 1) begin
                checks++;
                if (int'(if1.pixelX) != 0 || int'(if1.pixelY) != py_prev + 1) begin
                    errors++;
                    $display("FAIL hwrap got (%0d,%0d) want (0,%0d)", if1.pixelX, if1.pixelY, py_prev + 1);
                end
            end
        end
        checks++;
        if (lows != HSW) begin
            errors++;
            $display("FAIL hsync_width got %0d want %0d", lows, HSW);
        end
        checks++;
        if (first_x != HV + HF + 1) begin
            errors++;
            $display("FAIL hsync_first_x got %0d want %0d", first_x, HV + HF + 1);
        end
    endtask

    task automatic test_frame();
        int vlows = 0;
        int sofs = 0;
        int wraps = 0;
        int px_prev, py_prev;
        for (int i = 0; i < 2 * FRAME; i++) begin
            px_prev = int'(if1.pixelX);
            py_prev = int'(if1.pixelY);
            step(1'b1);
            if (!if1.vSync) vlows++;
            if (if1.startOfFrame) begin
                sofs++;
                checks++;
                if (int'(if1.pixelX) != 0 || int'(if1.pixelY) != VV) begin
                    errors++;
                    $display("FAIL sof_pos got (%0d,%0d) want (0,%0d)", if1.pixelX, if1.pixelY, VV);
                end
            end
            if (px_prev == HT - 1 && py_prev == VT - 1) begin
                wraps++;
                checks++;
                if ({if1.pixelX, if1.pixelY} !== 22'd0) begin
                    errors++;
                    $display("FAIL vwrap got (%0d,%0d) want (0,0)", if1.pixelX, if1.pixelY);
                end
            end
        end
        checks++;
        if (vlows != 2 * VSW * HT) begin
            errors++;
            $display("FAIL vsync_width got %0d want %0d", vlows, 2 * VSW * HT);
        end
        checks++;
        if (sofs != 2 || wraps != 2) begin
            errors++;
            $display("FAIL frame_events got sof=%0d wraps=%0d want 2/2", sofs, wraps);
        end
    endtask

    task automatic test_toggle();
        int first = -1;
        int second = -1;
        for (int i = 0; i < 4 * FRAME + 4; i++) begin
            step((i % 2) == 0);
            if (if1.startOfFrame) begin
                if (first < 0) first = cyc;
                else begin
                    second = cyc;
                    break;
                end
            end
        end
        checks++;
        if (first < 0 || second < 0 || second - first != 2 * FRAME) begin
            errors++;
            $display("FAIL toggle_period got first=%0d second=%0d want spacing %0d", first, second, 2 * FRAME);
        end
    endtask

    task automatic test_midreset();
        int first_x = -1;
        int first_y = -1;
        for (int i = 0; i < 2 * FRAME && !(mx == HV + HF + 3 && my == VV + VF + 1); i++) begin
            step(1'b1);
        end
        checks++;
        if ({if1.pixelX, if1.pixelY, if1.hSync, if1.vSync} !== {coord_t'(HV + HF + 3), coord_t'(VV + VF + 1), 2'b00}) begin
            errors++;
            $display("FAIL pre_reset got (%0d,%0d) hs=%b vs=%b want (%0d,%0d) 0 0", if1.pixelX, if1.pixelY,
                     if1.hSync, if1.vSync, HV + HF + 3, VV + VF + 1);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({if1.pixelX, if1.pixelY, if1.hSync, if1.vSync, if1.blankN, if3.hSync, if3.vSync} !== {22'd0, 5'b11011}) begin
            errors++;
            $display("FAIL async_reset got x=%0d y=%0d d1=%b d3=%b want 0 0 110 11", if1.pixelX, if1.pixelY,
                     {if1.hSync, if1.vSync, if1.blankN}, {if3.hSync, if3.vSync});
        end
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        for (int i = 0; i < HT; i++) begin
            step(1'b1);
            if ((!if1.hSync || !if1.vSync) && first_x < 0) begin
                first_x = int'(if1.pixelX);
                first_y = int'(if1.pixelY);
            end
        end
        checks++;
        if (first_x != HV + HF + 1 || first_y != 0) begin
            errors++;
            $display("FAIL post_reset_sync got (%0d,%0d) want (%0d,0)", first_x, first_y, HV + HF + 1);
        end
    endtask

    task automatic test_delay();
        int fall0 = -1;
        int fall3 = -1;
        logic b0, b3;
        b0 = if0.blankN;
        b3 = if3.blankN;
        for (int i = 0; i < HT; i++) begin
            step(1'b1);
            if (b0 && !if0.blankN && fall0 < 0) fall0 = int'(if0.pixelX);
            if (b3 && !if3.blankN && fall3 < 0) fall3 = int'(if3.pixelX);
            b0 = if0.blankN;
            b3 = if3.blankN;
        end
        checks++;
        if (fall0 != HV) begin
            errors++;
            $display("FAIL blank_d0 got x=%0d want %0d", fall0, HV);
        end
        checks++;
        if (fall3 != HV + 3) begin
            errors++;
            $display("FAIL blank_d3 got x=%0d want %0d", fall3, HV + 3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_toggle();
        test_midreset();
        test_delay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Upstream raster timing source for the VGA drawing pipeline. It produces the raw pixelX/pixelY coordinates consumed by the background and object drawers. It also produces the hSync/vSync/blankN signals. These are delayed by a configurable number of pixel steps so they stay aligned with the drawers' registered RGB output. A one-cycle startOfFrame pulse at entry to vertical blanking tells game logic when to update object positions.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_DELAY, 1, pixel steps of delay on hSync/vSync/blankN (0..7)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pixelEn  in  1  pixel strobe; counters advance only when 1 (tie to 1 for a 25 MHz clk)
pixelX  out  11  horizontal count 0..H_TOTAL-1, H_TOTAL = sum of H_*
pixelY  out  11  vertical count 0..V_TOTAL-1, V_TOTAL = sum of V_*
hSync  out  1  active-low horizontal sync, delayed SYNC_DELAY steps
vSync  out  1  active-low vertical sync, delayed SYNC_DELAY steps
blankN  out  1  1 = visible region, delayed SYNC_DELAY steps
startOfFrame  out  1  one-clk pulse when counters enter (0, V_VISIBLE)

Behaviour:
- Reset (async assert, sync release at next clk edge): pixelX=0, pixelY=0, hSync=1, vSync=1, blankN=0, startOfFrame=0. All delay-line stages are loaded with the same deasserted values.
- Counters are registered and update only on clk edges with pixelEn=1. With pixelEn=0, all outputs hold, except startOfFrame, which returns to 0.
- Horizontal: pixelX increments by 1. At H_TOTAL-1 it wraps to 0, and pixelY advances in the same cycle.
- Vertical: pixelY wraps from V_TOTAL-1 to 0 only when pixelX wraps. Both wraps occur in the same cycle; (799,524) -> (0,0) at the defaults.
- Undelayed timing, computed from the current counters:
  - hs_raw = 0 when H_VISIBLE+H_FRONT <= pixelX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751 at the defaults; 1 otherwise.
  - vs_raw = 0 when V_VISIBLE+V_FRONT <= pixelY < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491; 1 otherwise.
  - vis_raw = (pixelX < H_VISIBLE) && (pixelY < V_VISIBLE).
- Delay line: SYNC_DELAY-stage shift register carrying {hs_raw, vs_raw, vis_raw}. It shifts only on pixelEn=1.
  - The outputs are the last stage.
  - SYNC_DELAY=0: outputs equal the raw values combinationally.
  - With the default of 1, hSync falls one pixel step after pixelX becomes 656. This matches the drawers' one-register RGB latency.
- startOfFrame: registered. It is set to 1 for exactly one clk when a pixelEn=1 update moves the counters to pixelX=0, pixelY=V_VISIBLE; otherwise 0. It is never asserted twice per frame.
- pixelX/pixelY are not clamped. Values outside the visible area are passed through, and downstream drawers rely on blankN for masking.
- Width rule: all comparisons use 11-bit unsigned arithmetic. H_TOTAL and V_TOTAL must be <= 2047, enforced by an elaboration-time assertion.
- Reset mid-frame: the counters and the entire delay line clear immediately. No stale sync pulse emerges after release, and the first post-reset frame begins at (0,0).

Decomposition:
- Shared package vga_pkg:
  - typedef coord_t (logic [10:0]);
  - default timing constants H_VISIBLE..V_BACK;
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END.
- One sub-module, vga_sync_delay: parameterised-depth shift register with enable, async active-high reset, and reset value {1,1,0}. It is reused later for the object-drawer alignment.

Test Plan:
- Reset held 5 clks, pixelEn=1 -> pixelX=0, pixelY=0, hSync=1, vSync=1, blankN=0, startOfFrame=0 throughout; first post-release edge gives pixelX=1.
- pixelEn=1 for 800 clks -> hSync low for exactly 96 consecutive steps, first low step when pixelX=657 (SYNC_DELAY=1); pixelX wraps 799->0 and pixelY becomes 1 on the same edge.
- Run full frames -> pixelY wraps 524->0 with pixelX 799->0; vSync low exactly 1600 steps (lines 490-491); startOfFrame pulses once per 420000 steps, coincident with (0,480).
- pixelEn toggling 1,0,1,0 (50 MHz clk) -> counters change only on enabled edges; one frame takes 840000 clks; startOfFrame width stays 1 clk.
- Assert reset at pixelX=700, pixelY=491 (inside both syncs) -> hSync/vSync return to 1 asynchronously; after release no sync low until pixelX reaches 657 on line 0.
- SYNC_DELAY=0 and 3 builds -> blankN falls at pixelX=640 and 643 respectively, relative to the counter values.
